// File: rtl/dpram_bist_ctrl.sv
// March-style BIST controller driving one port of a dual-port block RAM.
// Sequence: write BG up; read BG / write ~BG up; read ~BG / write BG down;
// read BG down with a pipelined compare; one drain cycle. The first
// mismatch of a run is captured and held until the next start.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start                launch a run (honoured only in IDLE or DONE)
//   ram_wen/addr/d_in    registered RAM port controls (wen=1 write)
//   ram_d_out            RAM read data, valid the cycle after a read
//   busy, done, pass     run status
//   fail, fail_addr,
//   fail_data, fail_exp  sticky first-mismatch report
module dpram_bist_ctrl #(
  parameter int unsigned       ADDR_W  = 10,
  parameter int unsigned       DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(8'h55)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d_in,
  input  logic [DATA_W-1:0] ram_d_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_exp
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] BG       = PATTERN;
  localparam logic [DATA_W-1:0] BG_INV   = ~PATTERN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W0_UP,
    S_RW_UP,
    S_RW_DN,
    S_R_DN,
    S_R_LAST,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic                wen_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   din_nxt;
  logic                busy_nxt, done_nxt, pass_nxt, fail_nxt;
  logic [ADDR_W-1:0]   fail_addr_nxt;
  logic [DATA_W-1:0]   fail_data_nxt, fail_exp_nxt;
  logic                cmp_en;
  logic [ADDR_W-1:0]   cmp_addr;
  logic [DATA_W-1:0]   cmp_exp;

  // State and all outputs registered together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_d_in  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_exp  <= '0;
    end else begin
      state     <= state_nxt;
      ram_wen   <= wen_nxt;
      ram_addr  <= addr_nxt;
      ram_d_in  <= din_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      fail      <= fail_nxt;
      fail_addr <= fail_addr_nxt;
      fail_data <= fail_data_nxt;
      fail_exp  <= fail_exp_nxt;
    end
  end

  // Next state, next RAM access and compare selection.
  // In the RW elements ram_wen doubles as the cycle A (read) / B (write) flag.
  always_comb begin
    state_nxt     = state;
    wen_nxt       = 1'b0;
    addr_nxt      = ram_addr;
    din_nxt       = '0;
    busy_nxt      = busy;
    done_nxt      = done;
    fail_nxt      = fail;
    fail_addr_nxt = fail_addr;
    fail_data_nxt = fail_data;
    fail_exp_nxt  = fail_exp;
    cmp_en        = 1'b0;
    cmp_addr      = ram_addr;
    cmp_exp       = BG;

    case (state)
      S_IDLE, S_DONE: begin
        addr_nxt = '0;
        if (start) begin
          state_nxt     = S_W0_UP;
          busy_nxt      = 1'b1;
          done_nxt      = 1'b0;
          fail_nxt      = 1'b0;
          fail_addr_nxt = '0;
          fail_data_nxt = '0;
          fail_exp_nxt  = '0;
          wen_nxt       = 1'b1;
          din_nxt       = BG;
        end
      end

      S_W0_UP: begin
        if (ram_addr == ADDR_MAX) begin
          state_nxt = S_RW_UP;
          addr_nxt  = '0;
        end else begin
          wen_nxt  = 1'b1;
          din_nxt  = BG;
          addr_nxt = ram_addr + ADDR_W'(1);
        end
      end

      S_RW_UP: begin
        if (!ram_wen) begin
          wen_nxt = 1'b1;
          din_nxt = BG_INV;
        end else begin
          cmp_en  = 1'b1;
          cmp_exp = BG;
          if (ram_addr == ADDR_MAX) begin
            state_nxt = S_RW_DN;
            addr_nxt  = ADDR_MAX;
          end else begin
            addr_nxt = ram_addr + ADDR_W'(1);
          end
        end
      end

      S_RW_DN: begin
        if (!ram_wen) begin
          wen_nxt = 1'b1;
          din_nxt = BG;
        end else begin
          cmp_en  = 1'b1;
          cmp_exp = BG_INV;
          if (ram_addr == '0) begin
            state_nxt = S_R_DN;
            addr_nxt  = ADDR_MAX;
          end else begin
            addr_nxt = ram_addr - ADDR_W'(1);
          end
        end
      end

      // Compare lags the read by one cycle, so the data belongs to addr+1;
      // nothing is pending on the first cycle (addr still at the top).
      S_R_DN: begin
        cmp_en   = (ram_addr != ADDR_MAX);
        cmp_addr = ram_addr + ADDR_W'(1);
        if (ram_addr == '0) begin
          state_nxt = S_R_LAST;
          addr_nxt  = '0;
        end else begin
          addr_nxt = ram_addr - ADDR_W'(1);
        end
      end

      // Drain cycle: compare the final read of address 0.
      S_R_LAST: begin
        cmp_en    = 1'b1;
        cmp_addr  = '0;
        state_nxt = S_DONE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        addr_nxt  = '0;
      end

      default: begin
        state_nxt = S_IDLE;
        addr_nxt  = '0;
        busy_nxt  = 1'b0;
      end
    endcase

    // Only the first mismatch of a run is recorded.
    if (cmp_en && !fail && (ram_d_out != cmp_exp)) begin
      fail_nxt      = 1'b1;
      fail_addr_nxt = cmp_addr;
      fail_data_nxt = ram_d_out;
      fail_exp_nxt  = cmp_exp;
    end

    pass_nxt = done_nxt & ~fail_nxt;
  end

endmodule
